// File: rtl/scm_tcdm_arbiter_if.sv
// Two-port TCDM-style request/response bundle feeding the SCM bank arbiter.
// Index 0 is port0 and index 1 is port1 on every vector.
interface scm_tcdm_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [1:0]                 req;
    logic [1:0][31:0]           add;
    logic [1:0]                 wen;
    logic [1:0][BE_WIDTH-1:0]   be;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0]                 gnt;
    logic [1:0]                 r_valid;
    logic [DATA_WIDTH-1:0]      r_rdata;

    modport master (
        output req, add, wen, be, wdata,
        input  gnt, r_valid, r_rdata
    );

    modport slave (
        input  req, add, wen, be, wdata,
        output gnt, r_valid, r_rdata
    );
endinterface

// File: rtl/scm_tcdm_arbiter.sv
// Round-robin front end that folds two TCDM ports onto one latch-based SCM
// bank. Grants are combinational, so an access reaches the SCM in the request
// cycle. The response (read data or write ack) comes back one cycle later to
// the port that was granted.
module scm_tcdm_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    scm_tcdm_arbiter_if.slave     bus,
    output logic                  CEN,
    output logic                  WEN,
    output logic [BE_WIDTH-1:0]   BE,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    logic       rr_q;
    logic [1:0] rvalid_q;
    logic       rd_q;
    logic [1:0] gnt;
    logic       sel;
    logic       unused_addr_bits;

    // Grant selection: a lone requester wins, a tie goes to rr_q, reset masks all.
    always_comb begin
        gnt = 2'b00;
        if (RSTN) begin
            case (bus.req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // The port driving the SCM pins. When nothing is granted, it falls back to
    // the priority port, so the pins only change as far as that port's inputs do.
    assign sel = gnt[1] | (~gnt[0] & rr_q);

    assign CEN = ~(|gnt);
    assign WEN = bus.wen[sel];
    assign BE  = bus.be[sel];
    assign A   = bus.add[sel][ADDR_WIDTH+1:2];
    assign D   = bus.wdata[sel];

    // Byte-offset bits and bits above the bank size are ignored, so addresses alias.
    assign unused_addr_bits = ^{bus.add[1][31:ADDR_WIDTH+2], bus.add[1][1:0],
                                bus.add[0][31:ADDR_WIDTH+2], bus.add[0][1:0]};

    assign bus.gnt     = gnt;
    assign bus.r_valid = rvalid_q & {2{RSTN}};
    assign bus.r_rdata = (rd_q & RSTN & (|rvalid_q)) ? Q : '0;

    // Priority toggles to the loser of each grant; response tracking follows the grant.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rr_q     <= 1'b0;
            rvalid_q <= 2'b00;
            rd_q     <= 1'b0;
        end else begin
            if (|gnt) begin
                rr_q <= gnt[0];
            end
            rvalid_q <= gnt;
            rd_q     <= (|gnt) & bus.wen[sel];
        end
    end

endmodule
